// File: rtl/psw_cb_writer.sv
// Write-side controller for the PSW carry/borrow bit: carries EX-stage C/B results
// through M and W slots, retires them into the PSW register and forwards the newest value.
module psw_cb_writer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_cb_valid,
  input  logic             ex_nullified,
  input  logic             ex_cb,
  input  logic             ex_cb_use,
  input  logic             psw_cb,
  output logic             psw_le,
  output logic             psw_re,
  output logic             psw_data,
  output logic             cb_fwd,
  output logic [1:0]       cb_pending,
  output logic [CNT_W-1:0] cb_update_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             m_valid_q, m_valid_d;
  logic             m_cb_q, m_cb_d;
  logic             w_valid_q, w_valid_d;
  logic             w_cb_q, w_cb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // A retirement only happens when the pipeline moves; a stalled W stays pending.
  assign retire = w_valid_q & ~stall;

  always_comb begin
    m_valid_d = m_valid_q;
    m_cb_d    = m_cb_q;
    w_valid_d = w_valid_q;
    w_cb_d    = w_cb_q;
    cnt_d     = cnt_q;

    // Flush kills only what would be captured into M; old M contents still move to W.
    if (flush) begin
      m_valid_d = 1'b0;
    end else if (!stall) begin
      m_valid_d = ex_cb_valid & ~ex_nullified;
      m_cb_d    = ex_cb;
    end

    if (!stall) begin
      w_valid_d = m_valid_q;
      w_cb_d    = m_cb_q;
    end

    if (retire && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q <= 1'b0;
      m_cb_q    <= 1'b0;
      w_valid_q <= 1'b0;
      w_cb_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_cb_q    <= m_cb_d;
      w_valid_q <= w_valid_d;
      w_cb_q    <= w_cb_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs are gated by reset_n so they drop immediately while reset is held,
  // independent of the consumer request and the PSW register contents.
  always_comb begin
    psw_le   = reset_n & retire;
    psw_data = w_cb_q;
    psw_re   = reset_n & ex_cb_use & ~m_valid_q & ~w_valid_q;
    cb_fwd   = 1'b0;
    if (reset_n && ex_cb_use) begin
      if (m_valid_q) begin
        cb_fwd = m_cb_q;
      end else if (w_valid_q) begin
        cb_fwd = w_cb_q;
      end else begin
        cb_fwd = psw_cb;
      end
    end
  end

  assign cb_pending      = {1'b0, m_valid_q} + {1'b0, w_valid_q};
  assign cb_update_count = cnt_q;

endmodule

// File: tb/tb_psw_cb_writer.sv
// Bench for psw_cb_writer: per-cycle vector table, hand sequences for stall/flush/reset,
// and a retire scoreboard fed at stimulus time and drained on every psw_le pulse.
module tb_psw_cb_writer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             stall, flush, ex_cb_valid, ex_nullified, ex_cb, ex_cb_use;
  logic             psw_q;
  logic             psw_le, psw_re, psw_data, cb_fwd;
  logic [1:0]       cb_pending;
  logic [CNT_W-1:0] cb_update_count;

  logic exp_q[$];
  int   checks;
  int   errors;

  typedef struct {
    logic st, fl, v, nul, cb, cu;
    logic le, dat, re, fwd;
    logic [1:0] pend;
  } vec_t;

  vec_t tbl[12];

  psw_cb_writer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .ex_cb_valid(ex_cb_valid), .ex_nullified(ex_nullified), .ex_cb(ex_cb),
    .ex_cb_use(ex_cb_use), .psw_cb(psw_q), .psw_le(psw_le), .psw_re(psw_re),
    .psw_data(psw_data), .cb_fwd(cb_fwd), .cb_pending(cb_pending),
    .cb_update_count(cb_update_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The PSW C/B register the block writes into
  initial psw_q = 1'b0;
  always @(posedge clk) if (psw_le) psw_q <= psw_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every PSW write must match the oldest outstanding update
  always @(negedge clk) begin
    if (reset_n && psw_le) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_le: got psw_le=1 data=%0b expected no write at %0t", psw_data, $time);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (psw_data !== e) begin
          errors++;
          $display("FAIL sb_psw_data: got %0b expected %0b at %0t", psw_data, e, $time);
        end
      end
    end
  end

  task automatic set_idle();
    stall = 0; flush = 0; ex_cb_valid = 0; ex_nullified = 0; ex_cb = 0; ex_cb_use = 0;
  endtask

  // Drive one cycle's inputs just after the edge, then wait for the sampling edge.
  task automatic drive(input logic st, input logic fl, input logic v, input logic nul,
                       input logic cb, input logic cu);
    @(posedge clk); #1;
    stall = st; flush = fl; ex_cb_valid = v; ex_nullified = nul; ex_cb = cb; ex_cb_use = cu;
    if (v && !nul && !st && !fl) exp_q.push_back(cb);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_idle();
    reset_n = 1'b0;
    #12;
    check("rst_pending", cb_pending, 0);
    check("rst_le", psw_le, 0);
    check("rst_count", cb_update_count, 0);
    #5 reset_n = 1'b1;

    // Forward chain (rows 0-5), then nullify and forward-over-stale-PSW (rows 6-11)
    //            st fl v nul cb cu   le dat re fwd pend
    tbl[0]  = '{0, 0, 1, 0, 1, 0,   0, 0, 0, 0, 2'd0};
    tbl[1]  = '{0, 0, 1, 0, 0, 1,   0, 0, 0, 1, 2'd1};
    tbl[2]  = '{0, 0, 1, 0, 1, 1,   1, 1, 0, 0, 2'd2};
    tbl[3]  = '{0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 2'd2};
    tbl[4]  = '{0, 0, 0, 0, 0, 1,   1, 1, 0, 1, 2'd1};
    tbl[5]  = '{0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 2'd0};
    tbl[6]  = '{0, 0, 1, 1, 1, 1,   0, 0, 1, 1, 2'd0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 2'd0};
    tbl[8]  = '{0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 2'd0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 2'd1};
    tbl[10] = '{0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 2'd1};
    tbl[11] = '{0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 2'd0};
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].nul, tbl[i].cb, tbl[i].cu);
      check($sformatf("tbl%0d_le", i), psw_le, tbl[i].le);
      check($sformatf("tbl%0d_re", i), psw_re, tbl[i].re);
      check($sformatf("tbl%0d_fwd", i), cb_fwd, tbl[i].fwd);
      check($sformatf("tbl%0d_pend", i), cb_pending, tbl[i].pend);
      if (tbl[i].le) check($sformatf("tbl%0d_data", i), psw_data, tbl[i].dat);
    end
    check("tbl_count", cb_update_count, 4);

    // Single update: one pulse in cycle 3, PSW holds 1 from cycle 4
    do_reset();
    drive(0, 0, 1, 0, 1, 0); check("single_c1_le", psw_le, 0);
    drive(0, 0, 0, 0, 0, 0); check("single_c2_le", psw_le, 0);
    drive(0, 0, 0, 0, 0, 0); check("single_c3_le", psw_le, 1);
    check("single_c3_data", psw_data, 1);
    drive(0, 0, 0, 0, 0, 1); check("single_c4_le", psw_le, 0);
    check("single_count", cb_update_count, 1);
    check("single_psw", psw_q, 1);
    check("single_c4_re", psw_re, 1);
    check("single_c4_fwd", cb_fwd, 1);

    // Stall holds the pending write for two cycles
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); check("stall_c3_le", psw_le, 0); check("stall_c3_pend", cb_pending, 1);
    drive(1, 0, 0, 0, 0, 0); check("stall_c4_le", psw_le, 0); check("stall_c4_pend", cb_pending, 1);
    drive(0, 0, 0, 0, 0, 0); check("stall_c5_le", psw_le, 1); check("stall_c5_pend", cb_pending, 1);
    drive(0, 0, 0, 0, 0, 0); check("stall_c6_le", psw_le, 0); check("stall_c6_pend", cb_pending, 0);
    check("stall_count", cb_update_count, 1);
    check("stall_psw", psw_q, 0);

    // Reset mid-flight: outputs drop immediately, no write after release
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 1, 0);
    @(posedge clk); #1;
    set_idle();
    ex_cb_use = 1'b1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstmid_pend", cb_pending, 0);
    check("rstmid_le", psw_le, 0);
    check("rstmid_re", psw_re, 0);
    check("rstmid_fwd", cb_fwd, 0);
    check("rstmid_count", cb_update_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ex_cb_use = 1'b0;
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    check("rstmid_psw", psw_q, 0);
    check("rstmid_count_after", cb_update_count, 0);

    // Flush: older M entry still retires, the EX entry is dropped
    do_reset();
    drive(0, 0, 1, 0, 1, 0);
    drive(0, 1, 1, 0, 0, 0); check("flush_c2_pend", cb_pending, 1);
    drive(0, 0, 0, 0, 0, 0); check("flush_c3_le", psw_le, 1); check("flush_c3_data", psw_data, 1);
    drive(0, 0, 0, 0, 0, 0); check("flush_c4_le", psw_le, 0); check("flush_c4_pend", cb_pending, 0);
    // Flush with stall clears M outright
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0); check("flstall_pend", cb_pending, 1);
    void'(exp_q.pop_back());
    drive(0, 0, 0, 0, 0, 0); check("flstall_c7_pend", cb_pending, 0);
    drive(0, 0, 0, 0, 0, 0); check("flstall_c8_le", psw_le, 0);
    check("flush_count", cb_update_count, 1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 1'($urandom_range(0, 1)), 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    check("sat_count", cb_update_count, 15);

    // Random traffic with stalls and nullifies against the scoreboard
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 3) == 0), 1'b0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    check("rand_drained", exp_q.size(), 0);
    check("rand_count_sat", cb_update_count, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
